// File: rtl/keypad_matrix_scanner.sv
// Matrix keypad scanner: one-hot column drive, frame debounce, single held key; KEYPAD_REPEAT_EN adds auto-repeat.
// Latency: a key stable from frame n strobes OUT_press one cycle after the end of frame n+DEBOUNCE-1.
// Backpressure: none; OUT_press/OUT_release are single-cycle strobes that must be taken when issued.
module keypad_matrix_scanner #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int SCAN_DIV  = 1000,
    parameter int DEBOUNCE  = 3,
    parameter int REP_DELAY = 50,
    parameter int REP_RATE  = 10,
    localparam int CODE_W   = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic              IN_clk,
    input  logic              IN_reset,
    input  logic [ROWS-1:0]   IN_row,
    output logic [COLS-1:0]   OUT_col,
    output logic [CODE_W-1:0] OUT_code,
    output logic              OUT_key,
    output logic              OUT_press,
    output logic              OUT_release
);

    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int STB_W = $clog2(DEBOUNCE + 1);

    logic [DIV_W-1:0]  dwell_q;
    logic [COL_W-1:0]  col_q;
    logic              sample;
    logic              frame_end;

    logic              row_hit;
    logic [ROW_W-1:0]  row_sel;
    logic [CODE_W-1:0] hit_code;

    logic              cand_vld_q;
    logic [CODE_W-1:0] cand_code_q;
    logic              fin_vld;
    logic [CODE_W-1:0] fin_code;

    logic              prev_vld_q;
    logic [CODE_W-1:0] prev_code_q;
    logic [STB_W-1:0]  stable_q;
    logic [STB_W-1:0]  stable_nxt;
    logic              same_cand;
    logic              settled;
    logic              match_held;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0]  rep_cnt_q;
    logic              rep_run_q;
    logic              rep_fire;

    // First repeat waits REP_DELAY matching frames, later ones REP_RATE.
    always_comb begin
        rep_fire = rep_run_q ? (rep_cnt_q == REP_W'(REP_RATE - 1))
                             : (rep_cnt_q == REP_W'(REP_DELAY - 1));
    end
`endif

    always_comb begin
        sample    = (dwell_q == DIV_W'(SCAN_DIV - 1));
        frame_end = sample && (col_q == COL_W'(COLS - 1));
    end

    // Column 0 sits on the MSB of the column bus.
    always_comb begin
        OUT_col = '0;
        for (int c = 0; c < COLS; c++) begin
            OUT_col[COLS-1-c] = (col_q == COL_W'(c));
        end
    end

    // Row 0 sits on the MSB of the row bus; walk downwards so the lowest row wins.
    always_comb begin
        row_hit = 1'b0;
        row_sel = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (IN_row[ROWS-1-r]) begin
                row_hit = 1'b1;
                row_sel = ROW_W'(r);
            end
        end
        hit_code = CODE_W'(col_q) * CODE_W'(ROWS) + CODE_W'(row_sel);
    end

    // Candidate for the frame closing this cycle, including the last column's own sample.
    always_comb begin
        fin_vld    = cand_vld_q || row_hit;
        fin_code   = cand_vld_q ? cand_code_q : hit_code;
        same_cand  = (fin_vld == prev_vld_q) && (!fin_vld || (fin_code == prev_code_q));
        stable_nxt = !same_cand                      ? STB_W'(1) :
                     (stable_q == STB_W'(DEBOUNCE))  ? stable_q  :
                                                       stable_q + STB_W'(1);
        settled    = (stable_nxt >= STB_W'(DEBOUNCE));
        match_held = OUT_key && fin_vld && (fin_code == OUT_code);
    end

    always_ff @(posedge IN_clk) begin
        if (IN_reset) begin
            dwell_q     <= '0;
            col_q       <= '0;
            cand_vld_q  <= 1'b0;
            cand_code_q <= '0;
            prev_vld_q  <= 1'b0;
            prev_code_q <= '0;
            stable_q    <= '0;
            OUT_code    <= '0;
            OUT_key     <= 1'b0;
            OUT_press   <= 1'b0;
            OUT_release <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q   <= '0;
            rep_run_q   <= 1'b0;
`endif
        end else begin
            OUT_press   <= 1'b0;
            OUT_release <= 1'b0;

            if (sample) begin
                dwell_q <= '0;
                col_q   <= (col_q == COL_W'(COLS - 1)) ? '0 : col_q + COL_W'(1);
            end else begin
                dwell_q <= dwell_q + DIV_W'(1);
            end

            if (frame_end) begin
                cand_vld_q  <= 1'b0;
                cand_code_q <= '0;
                prev_vld_q  <= fin_vld;
                prev_code_q <= fin_code;
                stable_q    <= stable_nxt;

                if (match_held) begin
`ifdef KEYPAD_REPEAT_EN
                    if (rep_fire) begin
                        OUT_press <= 1'b1;
                        rep_cnt_q <= '0;
                        rep_run_q <= 1'b1;
                    end else begin
                        rep_cnt_q <= rep_cnt_q + REP_W'(1);
                    end
`endif
                end else if (settled) begin
                    if (!OUT_key && fin_vld) begin
                        OUT_code  <= fin_code;
                        OUT_key   <= 1'b1;
                        OUT_press <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt_q <= '0;
                        rep_run_q <= 1'b0;
`endif
                    end else if (OUT_key) begin
                        // Covers both an empty frame and a different key; a new key
                        // is taken at the following frame end with debounce already met.
                        OUT_key     <= 1'b0;
                        OUT_release <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt_q   <= '0;
                        rep_run_q   <= 1'b0;
`endif
                    end
                end
            end else if (sample && !cand_vld_q && row_hit) begin
                cand_vld_q  <= 1'b1;
                cand_code_q <= hit_code;
            end
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: directed frame table, hand sequences and randomized keys vs a cycle model.
module tb_keypad_matrix_scanner;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int SD    = 4;
    localparam int DB    = 3;
    localparam int RD    = 4;
    localparam int RR    = 2;
    localparam int FRAME = COLS * SD;
`ifdef KEYPAD_REPEAT_EN
    localparam int REP_P = 5;
`else
    localparam int REP_P = 1;
`endif

    logic            IN_clk = 1'b0;
    logic            IN_reset = 1'b1;
    logic [ROWS-1:0] IN_row;
    logic [COLS-1:0] OUT_col;
    logic [3:0]      OUT_code;
    logic            OUT_key;
    logic            OUT_press;
    logic            OUT_release;

    logic [15:0]     keys = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int press_seen = 0;
    int rel_seen   = 0;

    // Reference model state: integer key codes, -1 means no key.
    int m_t, m_cand, m_prev, m_stable, m_code, m_acc;
    bit m_held, m_press, m_rel;

    always #5 IN_clk = ~IN_clk;

    // Physical keypad: a closed switch connects its column line to its row line.
    always_comb begin
        IN_row = '0;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                if (OUT_col[COLS-1-c] && keys[c*ROWS+r]) IN_row[ROWS-1-r] = 1'b1;
            end
        end
    end

    keypad_matrix_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD), .DEBOUNCE(DB),
        .REP_DELAY(RD), .REP_RATE(RR)
    ) dut (
        .IN_clk(IN_clk),
        .IN_reset(IN_reset),
        .IN_row(IN_row),
        .OUT_col(OUT_col),
        .OUT_code(OUT_code),
        .OUT_key(OUT_key),
        .OUT_press(OUT_press),
        .OUT_release(OUT_release)
    );

    function automatic void m_frame_end(int f);
        if (f == m_prev) m_stable = (m_stable < DB) ? m_stable + 1 : DB;
        else             m_stable = 1;
        m_prev = f;
        if (m_held && f == m_code) begin
`ifdef KEYPAD_REPEAT_EN
            m_acc++;
            if (m_acc == RD || (m_acc > RD && (m_acc - RD) % RR == 0)) m_press = 1;
`endif
        end else if (m_stable >= DB) begin
            if (!m_held && f >= 0) begin
                m_held = 1; m_code = f; m_press = 1; m_acc = 0;
            end else if (m_held) begin
                m_held = 0; m_rel = 1;
            end
        end
    endfunction

    function automatic void model_step();
        int col;
        if (IN_reset) begin
            m_t = 0; m_cand = -1; m_prev = -1; m_stable = 0;
            m_held = 0; m_code = 0; m_acc = 0; m_press = 0; m_rel = 0;
        end else begin
            m_press = 0;
            m_rel   = 0;
            col = (m_t / SD) % COLS;
            if (m_t % SD == SD - 1) begin
                if (m_cand < 0) begin
                    for (int r = 0; r < ROWS; r++) begin
                        if (m_cand < 0 && keys[col*ROWS+r]) m_cand = col * ROWS + r;
                    end
                end
                if (col == COLS - 1) begin
                    m_frame_end(m_cand);
                    m_cand = -1;
                end
            end
            m_t++;
        end
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One clock: advance the model past the edge and compare every output.
    task automatic tick();
        logic [3:0] e_col;
        @(posedge IN_clk);
        #1;
        model_step();
        e_col = 4'b1000 >> ((m_t / SD) % COLS);
        n_tests++;
        if (OUT_col !== e_col || OUT_key !== m_held || OUT_code !== 4'(m_code) ||
            OUT_press !== m_press || OUT_release !== m_rel) begin
            n_fail++;
            $display("FAIL cycle t=%0d: dut col=%b key=%b code=%0d press=%b rel=%b, model col=%b key=%b code=%0d press=%b rel=%b",
                     m_t, OUT_col, OUT_key, OUT_code, OUT_press, OUT_release,
                     e_col, m_held, m_code, m_press, m_rel);
        end
        press_seen += int'(OUT_press);
        rel_seen   += int'(OUT_release);
    endtask

    typedef struct {
        logic [15:0] k;
        int          frames;
        int          presses;
        int          releases;
        int          key;
        int          code;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int n;
        bit found;
        logic [15:0] kk;
        int dur;

        tbl[0]  = '{16'h0000, 10, 0, 0, 0, 0};   // idle scan, no strobes
        tbl[1]  = '{16'h0040,  5, 1, 0, 1, 6};   // col1/row2 accepted once
        tbl[2]  = '{16'h0000,  3, 0, 1, 0, 6};   // release after 3 empty frames
        tbl[3]  = '{16'h0000,  2, 0, 0, 0, 6};
        tbl[4]  = '{16'h0200,  2, 0, 0, 0, 6};   // 2-frame glitch on code 9
        tbl[5]  = '{16'h0000,  3, 0, 0, 0, 6};
        tbl[6]  = '{16'h0022,  4, 1, 0, 1, 1};   // codes 1 and 5: scan priority gives 1
        tbl[7]  = '{16'h0020,  3, 0, 1, 0, 1};   // drop 1: release after debounce
        tbl[8]  = '{16'h0020,  1, 1, 0, 1, 5};   // 5 pressed at the next frame end
        tbl[9]  = '{16'h0000,  3, 0, 1, 0, 5};
        tbl[10] = '{16'h0008, 13, REP_P, 0, 1, 3}; // long hold: auto-repeat when enabled
        tbl[11] = '{16'h0000,  3, 0, 1, 0, 3};

        IN_reset = 1'b1;
        keys = '0;
        tick();
        tick();
        check("reset_col", int'(OUT_col), 8);
        check("reset_key", int'(OUT_key), 0);
        check("reset_code", int'(OUT_code), 0);
        check("reset_press", int'(OUT_press), 0);
        check("reset_release", int'(OUT_release), 0);
        IN_reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            keys = tbl[i].k;
            press_seen = 0;
            rel_seen = 0;
            for (int c = 0; c < tbl[i].frames * FRAME; c++) tick();
            check($sformatf("step%0d_presses", i), press_seen, tbl[i].presses);
            check($sformatf("step%0d_releases", i), rel_seen, tbl[i].releases);
            check($sformatf("step%0d_key", i), int'(OUT_key), tbl[i].key);
            check($sformatf("step%0d_code", i), int'(OUT_code), tbl[i].code);
        end

        // Press latency from idle: strobe in the cycle after the 3rd frame end.
        keys = 16'h0040;
        n = 0; found = 0;
        while (n < 100 && !found) begin
            tick();
            n++;
            if (OUT_press) found = 1;
        end
        check("press_latency", found ? n : -1, DB * FRAME);
        check("latency_code", int'(OUT_code), 6);

        // Reset in the middle of a hold clears everything and restarts debounce.
        for (int c = 0; c < 5; c++) tick();
        IN_reset = 1'b1;
        tick();
        check("midreset_col", int'(OUT_col), 8);
        check("midreset_key", int'(OUT_key), 0);
        check("midreset_code", int'(OUT_code), 0);
        check("midreset_strobes", int'({OUT_press, OUT_release}), 0);
        IN_reset = 1'b0;
        rel_seen = 0;
        n = 0; found = 0;
        while (n < 100 && !found) begin
            tick();
            n++;
            if (OUT_press) found = 1;
        end
        check("repress_latency", found ? n : -1, DB * FRAME);
        check("repress_no_release", rel_seen, 0);

        // Randomized keys with occasional resets, checked cycle by cycle.
        for (int j = 0; j < 60; j++) begin
            kk = '0;
            if ($urandom_range(0, 1) == 1) begin
                kk[$urandom_range(0, 15)] = 1'b1;
                if ($urandom_range(0, 2) == 0) kk[$urandom_range(0, 15)] = 1'b1;
            end
            keys = kk;
            dur = $urandom_range(1, 6) * FRAME;
            if ($urandom_range(0, 3) == 0) dur += $urandom_range(0, FRAME - 1);
            if ($urandom_range(0, 19) == 0) begin
                IN_reset = 1'b1;
                tick();
                IN_reset = 1'b0;
            end
            for (int c = 0; c < dur; c++) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
